// File: rtl/avalon_audio_fifo_slave.sv
// avalon_audio_fifo_slave
//   Avalon-MM slave that buffers audio samples written by the CPU and
//   drains them, in write order, onto a valid/ready stream toward the DAC.
//   A level-threshold interrupt requests a refill.
//
// Ports:
//   sys_clk        system clock
//   sys_rst        synchronous reset, active-high
//   avs_address    register word address (0 DATA, 1 STATUS, 2 CONTROL, 3 THRESHOLD)
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_read       read strobe
//   avs_readdata   registered read data (latency 1, holds when not reading)
//   irq            level-sensitive refill request
//   st_valid       stream sample valid
//   st_ready       downstream ready
//   st_data        stream sample (FIFO head)
module avalon_audio_fifo_slave #(
    parameter int DATA_W     = 24,
    parameter int DEPTH      = 16,
    parameter int THRESH_RST = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [1:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic              irq,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [DATA_W-1:0] st_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       level;
    logic              overflow;
    logic              underflow;
    logic              enable;
    logic [7:0]        threshold;

    logic              wr_data;
    logic              wr_status;
    logic              wr_ctrl;
    logic              wr_thresh;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              clear;
    logic              ovf_evt;
    logic              unf_evt;
    logic [AW:0]       level_nxt;
    logic              enable_nxt;
    logic [7:0]        thresh_nxt;
    logic              irq_nxt;
    logic [31:0]       status_word;
    logic [31:0]       rd_mux;

    always_comb begin
        wr_data   = avs_write && (avs_address == 2'd0);
        wr_status = avs_write && (avs_address == 2'd1);
        wr_ctrl   = avs_write && (avs_address == 2'd2);
        wr_thresh = avs_write && (avs_address == 2'd3);

        empty   = (level == '0);
        full    = (level == FULL_LEVEL);
        pop     = enable && !empty && st_ready;
        clear   = wr_ctrl && avs_writedata[1];
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push    = wr_data && (!full || pop);
        ovf_evt = wr_data && full && !pop;
        unf_evt = enable && st_ready && empty;

        level_nxt = level;
        if (clear) begin
            level_nxt = '0;
        end else if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level - 1'b1;
        end

        enable_nxt = wr_ctrl   ? avs_writedata[0]   : enable;
        thresh_nxt = wr_thresh ? avs_writedata[7:0] : threshold;
        irq_nxt    = enable_nxt && (9'(level_nxt) <= {1'b0, thresh_nxt});

        status_word = {16'h0000, 8'(level), 4'h0, underflow, overflow, full, empty};

        unique case (avs_address)
            2'd0:    rd_mux = '0;
            2'd1:    rd_mux = status_word;
            2'd2:    rd_mux = {31'd0, enable};
            default: rd_mux = {24'd0, threshold};
        endcase
    end

    // Storage is not reset; pointers and level define which entries are live.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && push) begin
            mem[wr_ptr] <= avs_writedata[DATA_W-1:0];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            enable       <= 1'b0;
            threshold    <= 8'(THRESH_RST);
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (clear) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
            end
            level <= level_nxt;

            // A new event in the same cycle as a W1C keeps the flag set.
            overflow  <= ovf_evt || (overflow  && !(wr_status && avs_writedata[2]));
            underflow <= unf_evt || (underflow && !(wr_status && avs_writedata[3]));

            enable    <= enable_nxt;
            threshold <= thresh_nxt;
            irq       <= irq_nxt;

            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

    assign st_valid = enable && !empty;
    assign st_data  = mem[rd_ptr];

endmodule

// File: tb/tb_avalon_audio_fifo_slave.sv
module tb_avalon_audio_fifo_slave;

    localparam int DATA_W     = 24;
    localparam int DEPTH      = 16;
    localparam int THRESH_RST = 8;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [1:0]        avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;
    logic              irq;
    logic              st_valid;
    logic              st_ready;
    logic [DATA_W-1:0] st_data;

    avalon_audio_fifo_slave #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .THRESH_RST(THRESH_RST)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .irq          (irq),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_data      (st_data)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: a queue of samples plus flag/register variables.
    logic [DATA_W-1:0] m_q[$];
    bit                m_ov, m_uf, m_en, m_irq;
    int                m_th;
    logic [31:0]       m_rdata;

    function automatic logic [31:0] reg_value(input logic [1:0] a);
        int lvl;
        lvl = m_q.size();
        case (a)
            2'd0:    return 32'd0;
            2'd1:    return (lvl << 8) | (int'(m_uf) << 3) | (int'(m_ov) << 2)
                            | (int'(lvl == DEPTH) << 1) | int'(lvl == 0);
            2'd2:    return 32'(m_en);
            default: return 32'(m_th);
        endcase
    endfunction

    task automatic model_update(input logic [1:0] a, input logic w, input logic [31:0] wd,
                                input logic r, input logic rdy, input logic rst);
        int lvl;
        bit do_pop, do_push, clr, ov_evt, uf_evt, en_n;
        int th_n;
        if (rst) begin
            m_q.delete();
            m_ov = 0; m_uf = 0; m_en = 0; m_th = THRESH_RST;
            m_rdata = '0; m_irq = 0;
            return;
        end
        lvl = m_q.size();
        if (r) m_rdata = reg_value(a);
        do_pop  = m_en && rdy && (lvl > 0);
        uf_evt  = m_en && rdy && (lvl == 0);
        do_push = 0; clr = 0; ov_evt = 0;
        en_n = m_en; th_n = m_th;
        if (w) begin
            case (a)
                2'd0: if (lvl < DEPTH || do_pop) do_push = 1; else ov_evt = 1;
                2'd1: begin
                    if (wd[2]) m_ov = 0;
                    if (wd[3]) m_uf = 0;
                end
                2'd2: begin
                    en_n = wd[0];
                    clr  = wd[1];
                end
                default: th_n = int'(wd[7:0]);
            endcase
        end
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back(wd[DATA_W-1:0]);
        if (clr)     m_q.delete();
        if (ov_evt)  m_ov = 1;
        if (uf_evt)  m_uf = 1;
        m_en  = en_n;
        m_th  = th_n;
        m_irq = m_en && (m_q.size() <= m_th);
    endtask

    task automatic step(input logic [1:0] a, input logic w, input logic [31:0] wd,
                        input logic r, input logic rdy, input logic rst);
        avs_address   = a;
        avs_write     = w;
        avs_writedata = wd;
        avs_read      = r;
        st_ready      = rdy;
        sys_rst       = rst;
        @(posedge sys_clk);
        model_update(a, w, wd, r, rdy, rst);
        @(negedge sys_clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic rdy);
        step(a, 1'b1, d, 1'b0, rdy, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a);
        step(a, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        step(2'd0, 1'b0, 32'd0, 1'b0, rdy, 1'b0);
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge sys_clk) begin
        if (chk_en) begin
            n_cmp++;
            if (st_valid !== (m_en && m_q.size() > 0)) begin
                n_bad++;
                $display("FAIL st_valid: got %b, expected %b at %0t", st_valid,
                         (m_en && m_q.size() > 0), $time);
            end
            if (m_en && m_q.size() > 0) begin
                n_cmp++;
                if (st_data !== m_q[0]) begin
                    n_bad++;
                    $display("FAIL st_data: got 0x%06h, expected 0x%06h at %0t", st_data, m_q[0], $time);
                end
            end
            n_cmp++;
            if (irq !== m_irq) begin
                n_bad++;
                $display("FAIL irq: got %b, expected %b at %0t", irq, m_irq, $time);
            end
            n_cmp++;
            if (avs_readdata !== m_rdata) begin
                n_bad++;
                $display("FAIL readdata: got 0x%08h, expected 0x%08h at %0t", avs_readdata, m_rdata, $time);
            end
        end
    end

    initial begin
        logic [31:0] wd;
        logic [1:0]  a;
        logic        w, r, rdy, rst;
        int          rdy_pct;
        int          sel;

        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        lit("rst_irq", 32'(irq), 32'd0);
        lit("rst_valid", 32'(st_valid), 32'd0);
        lit("rst_readdata", avs_readdata, 32'd0);

        rd(2'd0); lit("rd_data", avs_readdata, 32'd0);
        rd(2'd1); lit("rd_status_rst", avs_readdata, 32'h0000_0001);
        rd(2'd2); lit("rd_control_rst", avs_readdata, 32'd0);
        rd(2'd3); lit("rd_thresh_rst", avs_readdata, 32'd8);

        // Fill to full with the stream disabled, then overflow.
        for (int i = 0; i < DEPTH; i++) wr(2'd0, 32'(i + 1), 1'b0);
        rd(2'd1); lit("status_full", avs_readdata, 32'h0000_1002);
        wr(2'd0, 32'h00AB_CDEF, 1'b0);
        rd(2'd1); lit("status_ovf", avs_readdata, 32'h0000_1006);

        // Drain in order, then underflow.
        wr(2'd1, 32'h4, 1'b0);
        wr(2'd2, 32'h1, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            lit("drain_order", 32'(st_data), 32'(i + 1));
            idle(1'b1);
        end
        lit("drained_valid", 32'(st_valid), 32'd0);
        idle(1'b1);
        rd(2'd1); lit("status_unf", avs_readdata, 32'h0000_0009);
        lit("irq_low_level", 32'(irq), 32'd1);

        // Push and pop together while full.
        wr(2'd2, 32'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) wr(2'd0, 32'h100 + 32'(i), 1'b0);
        wr(2'd2, 32'h1, 1'b0);
        wr(2'd0, 32'h777, 1'b1);
        rd(2'd1); lit("status_full_pushpop", avs_readdata, 32'h0000_100A);
        for (int i = 0; i < DEPTH - 1; i++) idle(1'b1);
        lit("pushpop_sample_pos", 32'(st_data), 32'h777);

        // W1C and clear while popping.
        wr(2'd1, 32'hC, 1'b0);
        for (int i = 0; i < 4; i++) wr(2'd0, 32'h200 + 32'(i), 1'b0);
        rd(2'd1); lit("status_lvl5", avs_readdata, 32'h0000_0500);
        wr(2'd2, 32'h3, 1'b1);
        lit("clear_valid", 32'(st_valid), 32'd0);
        rd(2'd1); lit("status_cleared", avs_readdata, 32'h0000_0001);
        rd(2'd2); lit("control_after_clear", avs_readdata, 32'h0000_0001);

        // Threshold boundary.
        for (int i = 0; i < 3; i++) wr(2'd0, 32'h300 + 32'(i), 1'b0);
        lit("irq_lvl3_th8", 32'(irq), 32'd1);
        wr(2'd3, 32'h2, 1'b0);
        lit("irq_lvl3_th2", 32'(irq), 32'd0);
        idle(1'b1);
        lit("irq_lvl2_th2", 32'(irq), 32'd1);

        // Reset mid-stream with a concurrent DATA write.
        wr(2'd0, 32'h400, 1'b0);
        step(2'd0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1);
        lit("midrst_valid", 32'(st_valid), 32'd0);
        lit("midrst_irq", 32'(irq), 32'd0);
        lit("midrst_readdata", avs_readdata, 32'd0);
        rd(2'd1); lit("midrst_status", avs_readdata, 32'h0000_0001);
        rd(2'd3); lit("midrst_thresh", avs_readdata, 32'd8);

        // Randomized traffic checked cycle by cycle against the model.
        rdy_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                sel = $urandom_range(0, 2);
                rdy_pct = (sel == 0) ? 10 : (sel == 1) ? 50 : 90;
            end
            rst = ($urandom_range(0, 399) == 0);
            w   = ($urandom_range(0, 99) < 45);
            r   = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 99) < rdy_pct);
            sel = $urandom_range(0, 9);
            a   = (sel <= 5) ? 2'd0 : (sel == 6) ? 2'd1 : (sel == 7) ? 2'd2 :
                  (sel == 8) ? 2'd3 : 2'($urandom_range(0, 3));
            wd  = $urandom;
            if (a == 2'd2) begin
                wd[0] = ($urandom_range(0, 4) != 0);
                wd[1] = ($urandom_range(0, 7) == 0);
            end
            if (a == 2'd3 && $urandom_range(0, 3) != 0) wd[7:0] = 8'($urandom_range(0, DEPTH + 2));
            step(a, w, wd, r, rdy, rst);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/avalon_audio_fifo_slave.md
Name: avalon_audio_fifo_slave

Overview:
- Avalon-MM slave peripheral exported from the Nios II Qsys system, clocked by the 100 MHz PLL output.
- It is the responder end of the bus: the CPU writes audio samples into it.
- Samples are buffered in a FIFO and drained onto a valid/ready stream toward the DAC/I2S path.
- A level-threshold IRQ asks the CPU for a refill.

Parameters:
- DATA_W, 24, sample width in bits (1..32).
- DEPTH, 16, FIFO depth in samples; power of two, 2..128.
- THRESH_RST, 8, reset value of the THRESHOLD register (must be < DEPTH).

Ports:
- sys_clk  in  1  system clock (100 MHz domain).
- sys_rst  in  1  synchronous reset, active-high.
- avs_address  in  2  word address of the register.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, fixed read latency 1, no waitrequest.
- irq  out  1  refill request, level-sensitive.
- st_valid  out  1  stream sample valid.
- st_ready  in  1  downstream ready.
- st_data  out  DATA_W  stream sample, FIFO head.

Behaviour:
- One clock (sys_clk). sys_rst is synchronous and active-high, sampled on the rising edge.
- Reset clears:
  - FIFO empty, level=0.
  - overflow=0, underflow=0.
  - enable=0, THRESHOLD=THRESH_RST.
  - avs_readdata=0, irq=0, st_valid=0.
- Reset mid-transfer discards all FIFO contents; the write of that cycle is ignored.
- Register map (word address):
  - 0 DATA (WO): a write pushes writedata[DATA_W-1:0] if the FIFO is not full. If full, the sample is dropped and overflow is set (sticky). Reads return 0.
  - 1 STATUS: bit0=empty, bit1=full, bit2=overflow, bit3=underflow, bits[15:8]=level (zero-extended), other bits 0. Writing 1 to bit2/bit3 clears that flag (W1C); other bits are read-only.
  - 2 CONTROL: bit0=enable (R/W). bit1=clear, write-1 self-clearing: flushes the FIFO (level=0) in that cycle. bit1 reads 0; other bits 0.
  - 3 THRESHOLD: bits[7:0] R/W; upper bits read 0, writes ignored.
- Reads: avs_readdata is registered. The value reflects register state before any same-cycle write and is valid the cycle after avs_read. When avs_read is low, avs_readdata holds its last value.
- Simultaneous avs_read and avs_write: both are honoured; the read returns the pre-write value.
- Stream side:
  - st_valid = enable & !empty, combinational from registered state.
  - st_data = FIFO head.
  - A pop occurs when st_valid & st_ready.
  - Data is presented in write order; no reordering.
- Underflow: set (sticky) in any cycle where enable & st_ready & empty.
- Simultaneous push and pop:
  - FIFO full: the push is accepted (the pop frees a slot), level is unchanged, overflow is not set.
  - FIFO empty: no pop occurs; the push is accepted and level becomes 1.
- Clear vs. pop: a clear in the same cycle as a pop wins, level=0. The DATA push cannot coincide with a clear (single address per cycle).
- Pointers: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Level is log2(DEPTH)+1 bits, range 0..DEPTH. full = (level==DEPTH).
- irq: registered, irq <= enable & (level <= THRESHOLD), computed from next-state level. It rises/falls one cycle after the causing event and is deasserted one cycle after enable is cleared.
- Disabling (enable=0): the FIFO is retained, the stream stalls, no underflow is flagged.
- Mid-packet stall: if st_ready is low, st_data and st_valid hold stable until the pop.

Test Plan:
- Reset, then read all 4 registers -> DATA=0, STATUS=0x00000001, CONTROL=0, THRESHOLD=8; irq=0, st_valid=0.
- Write DATA 0x000001..0x000010 (16 samples), enable=0, read STATUS -> level=16, full=1, 0x00001002; a 17th write 0xABCDEF -> STATUS=0x00001006, FIFO contents unchanged.
- Set enable=1 with st_ready=1 continuously -> st_data 0x000001..0x000010 on 16 consecutive cycles; then underflow sets, STATUS=0x00000009; irq=1 once level<=8.
- FIFO full, st_ready=1, DATA write in the same cycle -> level stays 16, overflow stays 0, and the new sample emerges 16th after the current head.
- Write STATUS 0x0000000C -> overflow/underflow clear; write CONTROL 0x3 while level=5 and st_ready=1 -> next-cycle level=0, st_valid=0, enable=1.
- Write THRESHOLD=2 with level=3 -> irq=0; pop one sample -> irq=1 exactly one cycle later; assert sys_rst mid-stream -> the following cycle shows all reset values.
